// File: rtl/mult_pkg.sv
// Shared FSM state type and default operand width for the iterative
// carry-save multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 19;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_e;

endpackage

// File: rtl/csa_row.sv
// One 2*WIDTH-bit 3:2 compressor row: folds a partial product into a
// redundant sum/carry pair; the carry comes out already weighted by 2.
module csa_row #(
  parameter int WIDTH = 19
) (
  input  logic [2*WIDTH-1:0] sum,
  input  logic [2*WIDTH-1:0] carry,
  input  logic [2*WIDTH-1:0] pp,
  output logic [2*WIDTH-1:0] new_sum,
  output logic [2*WIDTH-1:0] new_carry
);

  logic [2*WIDTH-1:0] majority;

  assign new_sum   = sum ^ carry ^ pp;
  assign majority  = (sum & carry) | (sum & pp) | (carry & pp);
  assign new_carry = {majority[2*WIDTH-2:0], 1'b0};

endmodule

// File: rtl/csa_mult_iter.sv
// Iterative multiplier: one partial product per cycle accumulated in
// carry-save form, then a single carry-propagate add into z.
module csa_mult_iter
  import mult_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state;
  state_e          state_next;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic            signed_mode;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   carry;
  logic [CW-1:0]   count;

  logic            last;
  logic            negate;
  logic            eff_signed;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   row_pp;
  logic [PW-1:0]   row_sum;
  logic [PW-1:0]   row_carry;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign eff_signed = SIGNED_EN && is_signed;

  // The multiplicand shifts left and the multiplier right each cycle, so
  // bit 0 of mplier is y[count] and mcand is x_ext << count.
  assign last = (count == LAST);
  assign pp   = mplier[0] ? mcand : '0;

  // Two's-complement sign row: subtract as ~pp + 1, with the +1 dropped into
  // the carry LSB, which the compressor always leaves at zero.
  assign negate = signed_mode && last && mplier[0];
  assign row_pp = negate ? ~pp : pp;

  csa_row #(.WIDTH(WIDTH)) u_row (
    .sum       (sum),
    .carry     (carry),
    .pp        (row_pp),
    .new_sum   (row_sum),
    .new_carry (row_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: combinational processes assign every output a default first so no
  // path through the case leaves a latch behind.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ACCUM;
      ACCUM:   if (last)      state_next = RESOLVE;
      RESOLVE:                state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: operand registers are reset as well so an aborted operation leaves
  // no stale value behind and nothing downstream ever sees X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand       <= '0;
      mplier      <= '0;
      signed_mode <= 1'b0;
      sum         <= '0;
      carry       <= '0;
      count       <= '0;
      z           <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand       <= eff_signed ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
          mplier      <= y;
          signed_mode <= eff_signed;
          sum         <= '0;
          carry       <= '0;
          count       <= '0;
        end
        ACCUM: begin
          sum    <= row_sum;
          carry  <= row_carry | {{(PW-1){1'b0}}, negate};
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        RESOLVE: z <= sum + carry;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_mult_iter.sv
// Self-checking bench: three multiplier widths (8, 19, 32) driven by directed
// and random operations, checked against a plain-arithmetic product model.
module tb_csa_mult_iter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] x_bus = '0;
  logic [31:0] y_bus = '0;
  logic        sgn = 1'b0;
  logic [2:0]  in_valid_v = '0;
  logic [2:0]  out_ready_v = '0;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  busy_v;
  logic [15:0] z8;
  logic [37:0] z19;
  logic [63:0] z32;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  csa_mult_iter #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .x(x_bus[7:0]), .y(y_bus[7:0]), .is_signed(sgn), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .z(z8), .busy(busy_v[0]));

  csa_mult_iter #(.WIDTH(19)) u19 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .x(x_bus[18:0]), .y(y_bus[18:0]), .is_signed(sgn), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .z(z19), .busy(busy_v[1]));

  csa_mult_iter #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .x(x_bus), .y(y_bus), .is_signed(sgn), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .z(z32), .busy(busy_v[2]));

  function automatic int w_of(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 19 : 32;
  endfunction

  function automatic logic [63:0] get_z(input int sel);
    case (sel)
      0:       return {48'd0, z8};
      1:       return {26'd0, z19};
      default: return z32;
    endcase
  endfunction

  // Exact product reduced mod 2^(2w), computed with 64-bit integer arithmetic.
  function automatic logic [63:0] ref_mult(input int w, input logic [31:0] xv,
                                           input logic [31:0] yv, input logic s);
    longint      xs;
    longint      ys;
    logic [63:0] wmask;
    logic [63:0] pmask;
    logic [63:0] p;
    wmask = (64'd1 << w) - 64'd1;
    pmask = (2 * w == 64) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    xs = longint'({32'd0, xv} & wmask);
    ys = longint'({32'd0, yv} & wmask);
    if (s) begin
      xs = (xs <<< (64 - w)) >>> (64 - w);
      ys = (ys <<< (64 - w)) >>> (64 - w);
    end
    p = 64'(xs * ys);
    return p & pmask;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Call away from a rising edge with the chosen instance idle. Returns #1
  // after the edge on which the product is consumed.
  task automatic do_op(input int sel, input logic [31:0] xv, input logic [31:0] yv,
                       input logic s, input int hold, input logic [63:0] exp,
                       input string tag);
    int w = w_of(sel);
    int k = 0;
    check({tag, " in_ready"}, 64'(in_ready_v[sel]), 64'd1);
    x_bus = xv;
    y_bus = yv;
    sgn   = s;
    in_valid_v[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[sel] = 1'b0;
    x_bus = $urandom;
    y_bus = $urandom;
    sgn   = 1'($urandom);
    while (!out_valid_v[sel] && k < w + 10) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(w + 1));
    if (!out_valid_v[sel]) return;
    check({tag, " z"}, get_z(sel), exp);
    for (int i = 0; i < hold; i++) begin
      in_valid_v[sel] = 1'b1;
      x_bus = $urandom;
      @(posedge clk); #1;
      check({tag, " hold z"}, get_z(sel), exp);
      check({tag, " hold out_valid"}, 64'(out_valid_v[sel]), 64'd1);
      check({tag, " hold in_ready"}, 64'(in_ready_v[sel]), 64'd0);
    end
    in_valid_v[sel]  = 1'b0;
    out_ready_v[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[sel] = 1'b0;
    check({tag, " drop out_valid"}, 64'(out_valid_v[sel]), 64'd0);
    check({tag, " back in_ready"}, 64'(in_ready_v[sel]), 64'd1);
    check({tag, " z held"}, get_z(sel), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        seen_ov;
    logic [31:0] xv;
    logic [31:0] yv;
    logic        s;
    int          sel;
    int          w;

    // Reset state while reset_n is held low.
    #3;
    for (int i = 0; i < 3; i++) begin
      check("reset z", get_z(i), 64'd0);
      check("reset out_valid", 64'(out_valid_v[i]), 64'd0);
      check("reset busy", 64'(busy_v[i]), 64'd0);
      check("reset in_ready", 64'(in_ready_v[i]), 64'd1);
    end

    // Operands offered together with release: accepted on the first edge.
    @(negedge clk);
    reset_n = 1'b1;
    do_op(1, 32'h7FFFF, 32'h7FFFF, 1'b0, 0, 64'h3F_FFF0_0001, "max unsigned");
    do_op(1, 32'h40000, 32'h40000, 1'b1, 0, 64'h10_0000_0000, "min signed sq");
    do_op(1, 32'h7FFFF, 32'h00001, 1'b1, 1, 64'h3F_FFFF_FFFF, "minus one");
    do_op(1, 32'h00000, 32'h7FFFF, 1'b0, 0, 64'd0, "x zero unsigned");
    do_op(1, 32'h7FFFF, 32'h00000, 1'b1, 0, 64'd0, "y zero signed");
    do_op(1, 32'h7FFFF, 32'h00001, 1'b0, 0, 64'h7FFFF, "times one");
    do_op(0, 32'h80, 32'h80, 1'b1, 0, 64'h4000, "w8 min sq");
    do_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 64'hFFFF_FFFE_0000_0001, "w32 max");
    do_op(1, 32'h12345, 32'h6ABCD, 1'b1, 5, ref_mult(19, 32'h12345, 32'h6ABCD, 1'b1),
          "backpressure");

    // Abort mid-ACCUM: seven ACCUM edges have passed, so the counter holds 7.
    x_bus = 32'h5A5A5;
    y_bus = 32'h3C3C3;
    sgn   = 1'b0;
    in_valid_v[1] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort z", get_z(1), 64'd0);
    check("abort out_valid", 64'(out_valid_v[1]), 64'd0);
    check("abort busy", 64'(busy_v[1]), 64'd0);
    check("abort in_ready", 64'(in_ready_v[1]), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    seen_ov = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      seen_ov |= out_valid_v[1];
    end
    check("abort no out_valid", 64'(seen_ov), 64'd0);
    do_op(1, 32'h5A5A5, 32'h3C3C3, 1'b0, 0, ref_mult(19, 32'h5A5A5, 32'h3C3C3, 1'b0),
          "after abort");

    // Random operations on all widths, both modes, random back-pressure.
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 2);
      w   = w_of(sel);
      s   = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       xv = 32'd0;
        1:       xv = '1;
        2:       xv = 32'd1 << (w - 1);
        default: xv = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       yv = 32'd0;
        1:       yv = '1;
        2:       yv = 32'd1 << (w - 1);
        default: yv = $urandom;
      endcase
      do_op(sel, xv, yv, s, $urandom_range(0, 3), ref_mult(w, xv, yv, s),
            $sformatf("rand%0d w%0d s%0d", n, w, s));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_mult_iter.md
CSA_MULT_ITER -- requirements
Module: csa_mult_iter

Interface
REQ-001 Parameter WIDTH, default 19, operand width in bits; legal range 4..32.
REQ-002 Parameter SIGNED_EN, default 1; 1 = is_signed input honoured, 0 = is_signed ignored and all operations unsigned.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 x  input  WIDTH  multiplicand.
REQ-008 y  input  WIDTH  multiplier.
REQ-009 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with x and y.
REQ-010 out_valid  output  1  z holds a finished product.
REQ-011 out_ready  input  1  consumer takes z.
REQ-012 z  output  2*WIDTH  product.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, ACCUM, RESOLVE, DONE.
REQ-015 in_ready SHALL be high only in IDLE; acceptance = in_valid && in_ready on a rising edge.
REQ-016 On acceptance: register x, y and the effective signed flag; clear the sum and carry registers (2*WIDTH each); clear the bit counter; go to ACCUM.
REQ-017 ACCUM: one partial product per cycle, x gated by y[i] (i = counter, LSB first) and shifted left by i; fold it into sum/carry through one 3:2 compressor row; counter increments; after WIDTH cycles go to RESOLVE.
REQ-018 Signed mode: sign-extend x to 2*WIDTH; negate (subtract) the partial product for i = WIDTH-1; result equals the exact two's-complement product mod 2^(2*WIDTH).
REQ-019 Unsigned mode: zero-extend; result equals the exact unsigned product.
REQ-020 RESOLVE: one cycle; carry-propagate add of sum and carry into the z register; go to DONE.
REQ-021 Latency: out_valid SHALL rise on the rising edge WIDTH+1 edges after the acceptance edge (edge 20 for WIDTH=19).
REQ-022 DONE: out_valid high and z stable until out_valid && out_ready; on that edge go to IDLE, drop out_valid, set in_ready.
REQ-023 z SHALL hold its last value outside DONE; in_valid SHALL be ignored while busy; no operand change after acceptance affects the result.
REQ-024 Counter width $clog2(WIDTH+1); counter SHALL NOT wrap within an operation.

Reset
REQ-025 reset_n low SHALL force IDLE immediately, asynchronously, and zero z, out_valid, busy, counter, sum and carry; in_ready reads 1 once reset_n is low.
REQ-026 Reset asserted in ACCUM, RESOLVE or DONE SHALL abort the operation; no out_valid for the aborted operands after release.
REQ-027 First acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Structure
REQ-028 Package mult_pkg SHALL hold the FSM state enum type and the default-width constant (19).
REQ-029 Sub-module csa_row SHALL implement one parametrised 2*WIDTH-bit 3:2 compressor row (inputs sum, carry, partial product; outputs new sum, carry shifted left by one); instantiated once.
REQ-030 The RESOLVE adder is inferred with the + operator inside csa_mult_iter.

Verification
REQ-031 WIDTH=19, unsigned, x=0x7FFFF, y=0x7FFFF -> z=0x3F_FFF0_0001, out_valid on 20th edge after acceptance.
REQ-032 WIDTH=19, signed, x=0x40000 (-2^18), y=0x40000 -> z=0x10_0000_0000; signed, x=0x7FFFF (-1), y=1 -> z=0x3F_FFFF_FFFF.
REQ-033 x=0 or y=0 in either mode -> z=0; x=0x7FFFF, y=1 unsigned -> z=0x7FFFF.
REQ-034 out_ready held low 5 cycles in DONE -> z and out_valid stable, in_ready low, new in_valid ignored; out_ready high -> IDLE next edge.
REQ-035 reset_n pulsed low mid-ACCUM (counter=7) -> outputs zero immediately, no out_valid afterwards, next operand gives correct product.
REQ-036 1000 random operand pairs, both modes, random out_ready back-pressure, WIDTH in {8,19,32} -> every z matches a reference model, zero mismatches.
